string_lights_n: RTL and testbench
==================================

Name: string_lights_n

Overview:
- Parametrised successor to the lab string-lights pattern generator. Drives an N-LED string (LEDR on the DE1-SoC top) with four selectable patterns: calm alternate, march up, march down and bounce.
- Adds a programmable step prescaler, an enable input and a one-cycle step strobe.
- Sits between the board switch/key wrapper and LEDR; the top level ties mode, speed and enable to SW bits.

Parameters:
- N_LEDS, 10, number of LEDs in the string; legal values are 3 or more.
- DIV_W, 4, width of the speed/prescaler field.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- enable  input  1  1 = prescaler counts and pattern may advance; 0 = freeze all state.
- mode  input  2  00 calm, 01 march up (toward MSB), 10 march down (toward LSB), 11 bounce.
- speed  input  DIV_W  step occurs every speed+1 enabled cycles.
- leds  output  N_LEDS  registered LED pattern; bit 0 is the rightmost LED.
- tick  output  1  registered; high for exactly the one cycle in which a new leds value first appears.

Behaviour:
- Reset (reset==0 at a clk edge):
  - leds = CALM_A, mode_q = 00, cnt = 0, dir = up, tick = 0.
  - Reset overrides enable and any step in progress.
- Pattern definitions:
  - CALM_A has bit i = 1 for even i (...0101). CALM_B = ~CALM_A.
  - SEED_UP = one-hot bit 0. SEED_DN = one-hot bit N_LEDS-1.
- Prescaler:
  - cnt is DIV_W bits wide.
  - When enable=1: if cnt >= speed, the step is asserted and cnt <= 0; otherwise cnt <= cnt+1.
  - When enable=0: cnt, leds, mode_q and dir hold, and tick = 0.
  - speed=0 gives a step on every enabled cycle.
  - If speed is lowered below the current cnt, the step fires on the next enabled cycle (the >= compare); there is no wrap-around wait.
- On step, first case: mode != mode_q. Load the seed for the new mode and set mode_q <= mode; do not advance.
  - 00 loads CALM_A.
  - 01 loads SEED_UP.
  - 10 loads SEED_DN.
  - 11 loads SEED_UP with dir = up.
- On step, second case: mode == mode_q. Advance as follows:
  - 00: toggle between CALM_A and CALM_B.
  - 01: rotate left (MSB wraps to bit 0).
  - 10: rotate right (bit 0 wraps to MSB).
  - 11, dir=up: shift left; if the new lit bit is N_LEDS-1, set dir <= down.
  - 11, dir=down: shift right; if the new lit bit is 0, set dir <= up.
  - Bounce visits each end exactly once (no repeat at the ends). Period is 2*(N_LEDS-1) steps.
- Timing and latency:
  - A mode change is never visible before the next step boundary; mode is sampled only on step cycles.
  - leds changes only on step cycles. tick is the registered step, so tick and the new leds appear in the same cycle, one clk after the step condition is met.
- Defensive recovery: if leds is not one-hot in modes 01/10/11 (unreachable by design), the next step loads that mode's seed.
- The implementation contains no combinational path from inputs to outputs.

Test Plan:
- Reset and hold:
  - Stimulus: reset=0 for 2 cycles, then reset=1, enable=0 for 5 cycles.
  - Required response: leds=10'b0101010101 and tick=0 throughout.
- Calm at full rate:
  - Stimulus: enable=1, speed=0, mode=00.
  - Required response: leds alternates 0101010101 / 1010101010 every cycle and tick=1 every cycle.
- March up with wrap and mode reseed:
  - Stimulus: mode=01, speed=0.
  - Required response: the first step loads 0000000001, followed by 0000000010 … 1000000000, then 0000000001.
  - Follow-up stimulus: switch to mode=10 mid-sequence.
  - Required response: the next step loads 1000000000, then 0100000000.
- Prescaler:
  - Stimulus: speed=3, mode=01.
  - Required response: tick pulses once every 4 enabled cycles.
  - Follow-up stimulus: drop enable for 3 cycles mid-count.
  - Required response: the step is delayed by exactly 3 cycles.
  - Follow-up stimulus: lower speed from 7 to 1 when cnt=5.
  - Required response: the step fires on the next cycle.
- Bounce at N_LEDS=4:
  - Stimulus: mode=11, speed=0.
  - Required response: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; period 6 steps, no doubled end states.
- Reset mid-operation:
  - Stimulus: in bounce, dir=down, assert reset=0 for one cycle.
  - Required response: next cycle leds=CALM_A, tick=0. After release with mode=11, the first step loads 0001 with dir=up.

Source files
------------

// File: rtl/string_lights_n.sv
// rtl/string_lights_n.sv - parametrised N-LED string pattern generator with prescaled stepping
module string_lights_n #(
   parameter int N_LEDS = 10,
   parameter int DIV_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [DIV_W-1:0]  speed,
   output logic [N_LEDS-1:0] leds,
   output logic              tick
);

   typedef enum logic [1:0] {
      MODE_CALM   = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DN     = 2'b10,
      MODE_BOUNCE = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_t;

   // Even bits lit: ...0101
   function automatic logic [N_LEDS-1:0] calm_pattern();
      logic [N_LEDS-1:0] v;
      for (int i = 0; i < N_LEDS; i++) begin
         v[i] = ((i % 2) == 0);
      end
      return v;
   endfunction

   localparam logic [N_LEDS-1:0] CALM_A  = calm_pattern();
   localparam logic [N_LEDS-1:0] CALM_B  = ~CALM_A;
   localparam logic [N_LEDS-1:0] SEED_UP = {{(N_LEDS-1){1'b0}}, 1'b1};
   localparam logic [N_LEDS-1:0] SEED_DN = {1'b1, {(N_LEDS-1){1'b0}}};

   logic [DIV_W-1:0]  cnt;
   mode_t             mode_q;
   dir_t              dir;
   mode_t             mode_in;
   logic              step;
   logic              one_hot;
   logic [N_LEDS-1:0] next_leds;
   dir_t              next_dir;

   assign mode_in = mode_t'(mode);

   // The >= compare lets a lowered speed take effect on the very next enabled cycle.
   assign step = enable && (cnt >= speed);

   // Guards the moving-dot modes against a corrupted pattern.
   assign one_hot = (leds != '0) && ((leds & (leds - {{(N_LEDS-1){1'b0}}, 1'b1})) == '0);

   // Next pattern/direction, used only on step cycles.
   always_comb begin
      next_leds = leds;
      next_dir  = dir;
      if (mode_in != mode_q) begin
         // A new mode only reseeds; advancing starts on the following step.
         case (mode_in)
            MODE_CALM:   next_leds = CALM_A;
            MODE_UP:     next_leds = SEED_UP;
            MODE_DN:     next_leds = SEED_DN;
            MODE_BOUNCE: begin
               next_leds = SEED_UP;
               next_dir  = DIR_UP;
            end
         endcase
      end else begin
         case (mode_q)
            MODE_CALM: begin
               next_leds = (leds == CALM_A) ? CALM_B : CALM_A;
            end
            MODE_UP: begin
               if (!one_hot) next_leds = SEED_UP;
               else          next_leds = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
            end
            MODE_DN: begin
               if (!one_hot) next_leds = SEED_DN;
               else          next_leds = {leds[0], leds[N_LEDS-1:1]};
            end
            MODE_BOUNCE: begin
               if (!one_hot) begin
                  next_leds = SEED_UP;
                  next_dir  = DIR_UP;
               end else if (dir == DIR_UP) begin
                  if (leds[N_LEDS-1]) begin
                     // Already at the top with the wrong direction: turn around.
                     next_leds = leds >> 1;
                     next_dir  = DIR_DN;
                  end else begin
                     next_leds = leds << 1;
                     // Turn as the dot lands on the end so the end is shown once.
                     if (leds[N_LEDS-2]) next_dir = DIR_DN;
                  end
               end else begin
                  if (leds[0]) begin
                     next_leds = leds << 1;
                     next_dir  = DIR_UP;
                  end else begin
                     next_leds = leds >> 1;
                     if (leds[1]) next_dir = DIR_UP;
                  end
               end
            end
         endcase
      end
   end

   // Prescaler, pattern state and the registered step strobe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         leds   <= CALM_A;
         mode_q <= MODE_CALM;
         cnt    <= '0;
         dir    <= DIR_UP;
         tick   <= 1'b0;
      end else begin
         tick <= step;
         if (enable) begin
            if (step) begin
               cnt    <= '0;
               leds   <= next_leds;
               dir    <= next_dir;
               mode_q <= mode_in;
            end else begin
               cnt <= cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_string_lights_n.sv
// tb/tb_string_lights_n.sv - scoreboard bench for string_lights_n at N_LEDS=10 and N_LEDS=4
module tb_string_lights_n;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] speed = 4'd0;
   logic [9:0] leds10;
   logic       tick10;
   logic [3:0] leds4;
   logic       tick4;

   always #5 clk = ~clk;

   string_lights_n #(.N_LEDS(10), .DIV_W(4)) dut10 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .speed(speed),
      .leds(leds10), .tick(tick10)
   );

   string_lights_n #(.N_LEDS(4), .DIV_W(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .speed(speed),
      .leds(leds4), .tick(tick4)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Reference model: dot position / calm phase per string, shared prescaler count.
   int         m_cnt = 0;
   int         m_mode_q[2];
   int         m_phase[2];
   int         m_pos[2];
   int         m_dir[2];
   logic [9:0] cur[2];
   logic [9:0] exp_q0[$];
   logic [9:0] exp_q1[$];
   int         cyc = 0;

   function automatic int width_of(input int k);
      return (k == 0) ? 10 : 4;
   endfunction

   function automatic logic [9:0] model_leds(input int k);
      logic [9:0] v = '0;
      if (m_mode_q[k] == 0) begin
         for (int i = 0; i < width_of(k); i++) v[i] = ((i % 2) == m_phase[k]);
      end else begin
         v[m_pos[k]] = 1'b1;
      end
      return v;
   endfunction

   task automatic model_advance(input int k);
      int n = width_of(k);
      if (int'(mode) != m_mode_q[k]) begin
         m_mode_q[k] = int'(mode);
         case (int'(mode))
            0: m_phase[k] = 0;
            1: m_pos[k] = 0;
            2: m_pos[k] = n - 1;
            default: begin m_pos[k] = 0; m_dir[k] = 1; end
         endcase
      end else begin
         case (m_mode_q[k])
            0: m_phase[k] = 1 - m_phase[k];
            1: m_pos[k] = (m_pos[k] + 1) % n;
            2: m_pos[k] = (m_pos[k] + n - 1) % n;
            default: begin
               m_pos[k] = m_pos[k] + m_dir[k];
               if (m_pos[k] == n - 1) m_dir[k] = -1;
               else if (m_pos[k] == 0) m_dir[k] = 1;
            end
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
         m_cnt = 0;
         for (int k = 0; k < 2; k++) begin
            m_mode_q[k] = 0; m_phase[k] = 0; m_pos[k] = 0; m_dir[k] = 1;
         end
      end else if (enable) begin
         if (m_cnt >= int'(speed)) begin
            m_cnt = 0;
            model_advance(0);
            model_advance(1);
            exp_q0.push_back(model_leds(0));
            exp_q1.push_back(model_leds(1));
         end else begin
            m_cnt++;
         end
      end
      cur[0] = model_leds(0);
      cur[1] = model_leds(1);
   end

   // Monitor: pops the scoreboard whenever a tick is presented.
   bit         mon_on = 1'b0;
   logic [9:0] log10[$];
   logic [9:0] log4[$];
   int         stamp10[$];

   initial forever begin
      @(negedge clk);
      if (mon_on) begin
         if (tick10) begin
            if (exp_q0.size() == 0) fail_now("unexpected_tick10");
            else check("sb_leds10", leds10, exp_q0.pop_front());
            log10.push_back(leds10);
            stamp10.push_back(cyc);
         end else if (exp_q0.size() != 0) begin
            fail_now("missing_tick10");
            void'(exp_q0.pop_front());
         end
         if (tick4) begin
            if (exp_q1.size() == 0) fail_now("unexpected_tick4");
            else check("sb_leds4", {6'd0, leds4}, exp_q1.pop_front());
            log4.push_back({6'd0, leds4});
         end else if (exp_q1.size() != 0) begin
            fail_now("missing_tick4");
            void'(exp_q1.pop_front());
         end
         check("hold_leds10", leds10, cur[0]);
         check("hold_leds4", {6'd0, leds4}, cur[1]);
      end
   end

   task automatic cycles(input int k);
      repeat (k) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_tick10(output int stamp);
      int b = 0;
      stamp = 0;
      log10.delete();
      stamp10.delete();
      while (log10.size() == 0 && b < 40) begin
         cycles(1);
         b++;
      end
      if (log10.size() == 0) fail_now("wait_tick10_timeout");
      else stamp = stamp10[0];
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      logic [9:0] one10;
      logic [9:0] bt[8];
      int         t0, t1, t2;
      one10 = 10'd1;
      bt = '{10'h1, 10'h2, 10'h4, 10'h8, 10'h4, 10'h2, 10'h1, 10'h2};

      // Reset and hold
      reset = 1'b0; enable = 1'b0; mode = 2'b00; speed = 4'd0;
      cycles(2);
      mon_on = 1'b1;
      check("reset_leds10", leds10, 10'b0101010101);
      check("reset_tick10", tick10, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycles(1);
         check("hold_calm", leds10, 10'b0101010101);
         check("hold_tick", tick10, 1'b0);
      end

      // Calm at full rate
      enable = 1'b1; speed = 4'd0; mode = 2'b00;
      log10.delete();
      cycles(6);
      check("calm_count", log10.size(), 6);
      for (int i = 0; i < 6 && i < log10.size(); i++)
         check("calm_seq", log10[i], (i % 2 == 0) ? 10'b1010101010 : 10'b0101010101);

      // March up with wrap, then reseed to march down
      mode = 2'b01;
      log10.delete();
      cycles(11);
      check("up_count", log10.size(), 11);
      for (int i = 0; i < 11 && i < log10.size(); i++)
         check("up_seq", log10[i], one10 << (i % 10));
      cycles(3);
      mode = 2'b10;
      log10.delete();
      cycles(2);
      check("dn_count", log10.size(), 2);
      if (log10.size() == 2) begin
         check("dn_seed", log10[0], 10'b1000000000);
         check("dn_next", log10[1], 10'b0100000000);
      end

      // Prescaler
      mode = 2'b01; speed = 4'd3;
      wait_tick10(t0);
      log10.delete();
      stamp10.delete();
      cycles(16);
      check("presc_count", stamp10.size(), 4);
      for (int i = 0; i < stamp10.size(); i++)
         check("presc_period", stamp10[i] - t0, 4 * (i + 1));
      t0 = t0 + 16;
      cycles(1);
      enable = 1'b0;
      cycles(3);
      enable = 1'b1;
      wait_tick10(t1);
      check("enable_gap", t1 - t0, 7);
      speed = 4'd7;
      cycles(5);
      speed = 4'd1;
      wait_tick10(t2);
      check("speed_lower", t2 - t1, 6);

      // Bounce on the 4-LED string
      mode = 2'b11; speed = 4'd0;
      log4.delete();
      cycles(8);
      check("bounce_count", log4.size(), 8);
      for (int i = 0; i < 8 && i < log4.size(); i++)
         check("bounce_seq", log4[i], bt[i]);

      // Reset mid-bounce while moving down
      cycles(3);
      check("bounce_down_pos", {28'd0, leds4}, 32'h4);
      reset = 1'b0;
      cycles(1);
      check("midreset_leds10", leds10, 10'b0101010101);
      check("midreset_leds4", {28'd0, leds4}, 32'h5);
      check("midreset_tick", tick4, 1'b0);
      reset = 1'b1;
      log4.delete();
      cycles(3);
      check("rebounce_count", log4.size(), 3);
      for (int i = 0; i < 3 && i < log4.size(); i++)
         check("rebounce_seq", log4[i], bt[i]);

      // Randomised traffic against the model
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) speed = 4'($urandom_range(0, 5));
         enable = ($urandom_range(0, 7) != 0);
         reset  = ($urandom_range(0, 63) != 0);
         cycles(1);
      end
      reset = 1'b1;
      enable = 1'b0;
      cycles(2);
      check("sb_drain", exp_q0.size() + exp_q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
